wb_data_master_bridge: RTL and testbench
========================================

// Module: wb_data_master_bridge
// PURPOSE
//  Wishbone B4 classic master on the MEM-stage data path, directly downstream of the atomic access controller.
//  Converts its level-held mem_read/mem_write requests into single Wishbone cycles.
//  Returns a registered one-cycle mem_ack with read data.
//  Holds wb_cyc_o/wb_lock_o across the read and write halves of an AMO so the read-modify-write is indivisible.
//  Adds bus-error and timeout reporting.
// PARAMETERS
//  DW          32   data width (bits); byte select width = DW/8
//  AW          32   requester address width; wb_adr_o = mem_addr[AW-1:2]
//  TIMEOUT     255  cycles in BUS without wb_ack_i/wb_err_i before forced error; 0 disables the timeout
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  mem_read    in   1       read request, held until mem_ack
//  mem_write   in   1       write request, held until mem_ack (wins over mem_read if both high)
//  mem_addr    in   AW      byte address; bits [1:0] ignored
//  mem_wdata   in   DW      write data
//  mem_be      in   DW/8    byte enables (4'hF for word/AMO)
//  mem_lock    in   1       high while an AMO/LR-SC sequence owns the bus
//  mem_rdata   out  DW      read data, valid in mem_ack cycle; holds until next read ack
//  mem_ack     out  1       one-cycle completion pulse
//  mem_err     out  1       high with mem_ack when the access failed (wb_err_i or timeout)
//  wb_cyc_o    out  1       Wishbone cycle
//  wb_stb_o    out  1       Wishbone strobe
//  wb_we_o     out  1       Wishbone write enable
//  wb_adr_o    out  AW-2    word address
//  wb_dat_o    out  DW      write data
//  wb_sel_o    out  DW/8    byte selects
//  wb_lock_o   out  1       bus lock
//  wb_dat_i    in   DW      read data
//  wb_ack_i    in   1       slave ack
//  wb_err_i    in   1       slave error
// BEHAVIOUR
//  Reset:
//   - All outputs are 0; state goes to IDLE; timeout counter is 0; lock_held is 0.
//   - Asserting rst mid-cycle drops cyc/stb/lock asynchronously. Any pending request is lost and no mem_ack is produced.
//  FSM states: IDLE, BUS, RESP.
//   - IDLE: if (mem_read|mem_write), register adr/dat/sel/we and set wb_stb_o=1, wb_cyc_o=1, then go to BUS. Otherwise stay.
//     wb_we_o = mem_write.
//   - BUS: stb/cyc are held and all outputs are stable.
//     - wb_ack_i: capture wb_dat_i if read; drop stb; go to RESP.
//     - wb_err_i, or the counter reaches TIMEOUT: drop stb; set err_q; go to RESP.
//     - wb_err_i takes priority over wb_ack_i in the same cycle.
//   - RESP: mem_ack=1 for exactly this cycle; mem_err=err_q; mem_rdata=captured data (0 on error read). Next state is IDLE.
//     The requester changes or drops its request on this edge.
//     IDLE then samples the next request, so back-to-back accesses are 3 cycles apart minimum.
//  Latency:
//   - Request seen in IDLE at cycle 0, stb at cycle 1.
//   - Slave ack at cycle k gives mem_ack at cycle k+1.
//   - Zero-wait slave: mem_ack at cycle 2.
//  Timeout:
//   - The counter clears on entry to BUS and increments each BUS cycle.
//   - Error is forced when count == TIMEOUT-1 with no ack.
//  Lock:
//   - lock_held is set when a request is accepted with mem_lock=1.
//   - While lock_held=1: wb_lock_o=1 and wb_cyc_o stays 1 through RESP and IDLE; wb_stb_o is 0 outside BUS.
//   - lock_held clears in IDLE when mem_lock=0, or after any mem_err.
//     cyc and lock then fall on the next edge.
//  Arithmetic and width rules:
//   - No arithmetic on data.
//   - The counter is $clog2(TIMEOUT+1) bits and saturates, never wraps.
//  Ignored conditions:
//   - Requests arriving in BUS or RESP are ignored; inputs are sampled only in IDLE.
//   - mem_read & mem_write together is treated as a write.
// STRUCTURE
//  Package soc_bus_pkg:
//   - wb_state_t enum {IDLE, BUS, RESP};
//   - localparams WB_SEL_WORD=4'hF and DEFAULT_TIMEOUT=255.
//  One sub-module, bus_timeout_ctr: clear, enable, TIMEOUT parameter, expired output.
//  The remainder (FSM plus output registers) is a single always_ff / always_comb pair.
// TESTING
//  - Read, zero-wait slave:
//    - mem_read=1, mem_addr=32'h0000_1004.
//    - Slave acks in cycle 1 with 32'hDEAD_BEEF.
//    - Expect wb_adr_o=30'h401, wb_sel_o=4'hF, mem_ack at cycle 2, mem_rdata=32'hDEAD_BEEF, mem_err=0.
//  - Write, 3 wait states:
//    - mem_write=1, mem_wdata=32'h1234_5678, mem_be=4'b0011.
//    - Expect wb_we_o=1, wb_sel_o=4'b0011, stb held 4 cycles, a single mem_ack, then cyc=0.
//  - AMO lock:
//    - mem_lock=1 with a read, then (after RESP) a write to the same address.
//    - Expect wb_cyc_o and wb_lock_o continuously 1 from the first stb until mem_lock=0 in IDLE.
//    - Expect exactly 2 stb pulses.
//  - Slave error:
//    - wb_err_i asserted on a read at cycle 1.
//    - Expect mem_ack=1, mem_err=1, mem_rdata=0, lock released.
//  - Timeout with TIMEOUT=8:
//    - Slave never responds.
//    - Expect stb dropped and mem_ack+mem_err=1 exactly 8 BUS cycles after stb rose, plus 1.
//  - Reset mid-BUS:
//    - rst asserted 2 cycles into a wait-stated read.
//    - Expect cyc/stb/lock=0 immediately and no mem_ack.
//    - After rst is released, a new read completes normally.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the MEM-stage Wishbone data master.
// Imported by the bridge and its testbench.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [3:0] WB_SEL_WORD     = 4'hF;
    localparam int         DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating cycle counter that flags a stalled Wishbone slave.
// TIMEOUT of 0 disables the expired flag.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CAP = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != CAP)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && enable && (cnt_q == LAST);

endmodule

// File: rtl/wb_data_master_bridge.sv
// Wishbone B4 classic master for MEM-stage loads, stores and AMOs.
// One bus cycle per request; cyc/lock stay up across a locked AMO pair.
module wb_data_master_bridge
    import soc_bus_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_be,
    input  logic            mem_lock,
    output logic [DW-1:0]   mem_rdata,
    output logic            mem_ack,
    output logic            mem_err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-3:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_lock_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i
);

    wb_state_t       state_q, state_d;
    logic            cyc_d, stb_d, we_d, lock_d;
    logic            ack_d, err_d;
    logic [AW-3:0]   adr_d;
    logic [DW-1:0]   dat_d, rdata_d;
    logic [DW/8-1:0] sel_d;
    logic            ctr_clr, ctr_exp;
    logic            addr_unused;

    assign addr_unused = ^mem_addr[1:0];

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clr),
        .enable  (state_q == BUS),
        .expired (ctr_exp)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = wb_cyc_o;
        stb_d   = wb_stb_o;
        we_d    = wb_we_o;
        adr_d   = wb_adr_o;
        dat_d   = wb_dat_o;
        sel_d   = wb_sel_o;
        lock_d  = wb_lock_o;
        rdata_d = mem_rdata;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ctr_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = mem_write;
                    adr_d   = mem_addr[AW-1:2];
                    dat_d   = mem_wdata;
                    sel_d   = mem_be;
                    lock_d  = mem_lock;
                    ctr_clr = 1'b1;
                end else if (!mem_lock) begin
                    lock_d = 1'b0;
                    cyc_d  = 1'b0;
                end
            end
            BUS: begin
                // A slave ack in the final allowed cycle beats the timeout.
                if (wb_err_i || (!wb_ack_i && ctr_exp)) begin
                    state_d = RESP;
                    stb_d   = 1'b0;
                    cyc_d   = wb_lock_o;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    if (!wb_we_o) rdata_d = '0;
                end else if (wb_ack_i) begin
                    state_d = RESP;
                    stb_d   = 1'b0;
                    cyc_d   = wb_lock_o;
                    ack_d   = 1'b1;
                    if (!wb_we_o) rdata_d = wb_dat_i;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (mem_err) begin
                    lock_d = 1'b0;
                    cyc_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            wb_lock_o <= 1'b0;
            mem_rdata <= '0;
            mem_ack   <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_cyc_o  <= cyc_d;
            wb_stb_o  <= stb_d;
            wb_we_o   <= we_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            wb_sel_o  <= sel_d;
            wb_lock_o <= lock_d;
            mem_rdata <= rdata_d;
            mem_ack   <= ack_d;
            mem_err   <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_data_master_bridge.sv
// Directed and randomized bench for wb_data_master_bridge.
// A scripted slave answers each cycle; a transaction-level model predicts results.
module tb_wb_data_master_bridge;
    import soc_bus_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_lock;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack, mem_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;
    int n_rise = 0;
    int n_cyc_low = 0;

    // slave script: wait cycles, mode 0 ack / 1 err / 2 silent / 3 ack+err
    int          s_wait = 0;
    int          s_mode = 0;
    logic [31:0] s_data = '0;
    logic [31:0] last_rd = '0;

    wb_data_master_bridge #(
        .DW      (32),
        .AW      (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_lock  (mem_lock),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_err   (mem_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_lock_o (wb_lock_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    always #5 clk = ~clk;

    initial begin
        int s_cnt;
        s_cnt = 0;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_stb_o && wb_cyc_o) begin
                if (s_cnt == s_wait) begin
                    if (s_mode == 1 || s_mode == 3) wb_err_i = 1'b1;
                    if (s_mode == 0 || s_mode == 3) begin
                        wb_ack_i = 1'b1;
                        wb_dat_i = s_data;
                    end
                end
                s_cnt++;
            end else begin
                s_cnt = 0;
            end
        end
    end

    initial begin
        logic prev_stb;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_ack) n_ack++;
            if (!wb_cyc_o) n_cyc_low++;
            if (wb_stb_o && !prev_stb) n_rise++;
            prev_stb = wb_stb_o;
        end
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returning on a negedge of an IDLE cycle.
    task automatic access(input bit          wr,
                          input bit          both,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          input logic [3:0]  be,
                          input bit          lk,
                          input int          wt,
                          input int          md,
                          input logic [31:0] sd);
        int          lat, stbc, exp_lat, exp_stb;
        bit          done, exp_err, exp_hold;
        logic [31:0] exp_rd;
        exp_err  = (md != 0);
        exp_lat  = (md == 2) ? TMO + 1 : wt + 2;
        exp_stb  = (md == 2) ? TMO : wt + 1;
        exp_rd   = wr ? last_rd : (exp_err ? 32'h0 : sd);
        exp_hold = lk && !exp_err;
        s_wait = wt;
        s_mode = md;
        s_data = sd;
        mem_read  = !wr || both;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        mem_be    = be;
        mem_lock  = lk;
        lat  = 0;
        stbc = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (wb_stb_o) stbc++;
            if (lat == 1) begin
                chk("adr", 64'(wb_adr_o), 64'(a[31:2]));
                chk("sel", 64'(wb_sel_o), 64'(be));
                chk("we", 64'(wb_we_o), 64'(wr));
                chk("cyc_bus", 64'(wb_cyc_o), 64'(1));
                chk("lock_bus", 64'(wb_lock_o), 64'(lk));
                if (wr) chk("dat_o", 64'(wb_dat_o), 64'(wd));
            end
            if (mem_ack) done = 1'b1;
        end
        chk("ack_latency", 64'(lat), 64'(exp_lat));
        chk("stb_cycles", 64'(stbc), 64'(exp_stb));
        chk("mem_err", 64'(mem_err), 64'(exp_err));
        chk("mem_rdata", 64'(mem_rdata), 64'(exp_rd));
        chk("cyc_resp", 64'(wb_cyc_o), 64'(lk));
        chk("stb_resp", 64'(wb_stb_o), 64'(0));
        if (!wr) last_rd = exp_rd;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 64'(mem_ack), 64'(0));
        chk("cyc_idle", 64'(wb_cyc_o), 64'(exp_hold));
        chk("lock_idle", 64'(wb_lock_o), 64'(exp_hold));
    endtask

    initial begin
        int s_rise, s_low, s_ack;
        bit wr;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_lock  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", 64'(mem_ack), 64'(0));
        chk("rst_err", 64'(mem_err), 64'(0));
        chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
        chk("rst_stb", 64'(wb_stb_o), 64'(0));
        chk("rst_lock", 64'(wb_lock_o), 64'(0));
        chk("rst_rdata", 64'(mem_rdata), 64'(0));
        chk("rst_adr", 64'(wb_adr_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        access(0, 0, 32'h0000_1004, 32'h0, WB_SEL_WORD,
               0, 0, 0, 32'hDEAD_BEEF);
        chk("adr_401", 64'(wb_adr_o), 64'(30'h401));

        access(1, 0, 32'h0000_2008, 32'h1234_5678, 4'b0011,
               0, 3, 0, 32'h0);

        s_rise = n_rise;
        access(0, 0, 32'h0000_3000, 32'h0, WB_SEL_WORD,
               1, 1, 0, 32'hA5A5_0001);
        s_low = n_cyc_low;
        access(1, 0, 32'h0000_3000, 32'hA5A5_0002, WB_SEL_WORD,
               1, 2, 0, 32'h0);
        mem_lock = 1'b0;
        @(negedge clk);
        chk("amo_cyc_gap", 64'(n_cyc_low - s_low), 64'(0));
        chk("amo_stb_pulses", 64'(n_rise - s_rise), 64'(2));
        chk("amo_cyc_drop", 64'(wb_cyc_o), 64'(0));
        chk("amo_lock_drop", 64'(wb_lock_o), 64'(0));

        access(0, 0, 32'h0000_4000, 32'h0, WB_SEL_WORD,
               1, 0, 1, 32'hFFFF_FFFF);
        mem_lock = 1'b0;
        access(0, 0, 32'h0000_4004, 32'h0, WB_SEL_WORD,
               0, 0, 3, 32'h7777_7777);
        access(0, 0, 32'h0000_5000, 32'h0, WB_SEL_WORD,
               0, 0, 2, 32'h1111_1111);
        access(0, 0, 32'h0000_5004, 32'h0, WB_SEL_WORD,
               0, TMO - 1, 0, 32'h2222_2222);
        access(1, 1, 32'h0000_6000, 32'hCAFE_F00D, 4'b1100,
               0, 1, 0, 32'h3333_3333);

        s_ack = n_ack;
        s_wait    = 5;
        s_mode    = 0;
        mem_read  = 1'b1;
        mem_lock  = 1'b1;
        mem_addr  = 32'h0000_7000;
        mem_be    = WB_SEL_WORD;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cyc", 64'(wb_cyc_o), 64'(0));
        chk("rst_mid_stb", 64'(wb_stb_o), 64'(0));
        chk("rst_mid_lock", 64'(wb_lock_o), 64'(0));
        mem_read = 1'b0;
        mem_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_rd = '0;
        @(negedge clk);
        chk("rst_no_ack", 64'(n_ack - s_ack), 64'(0));
        access(0, 0, 32'h0000_7004, 32'h0, WB_SEL_WORD,
               0, 2, 0, 32'h0BAD_CAFE);

        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            access(wr, 1'($urandom_range(0, 1)), $urandom, $urandom,
                   4'($urandom_range(1, 15)), 0,
                   $urandom_range(0, 5),
                   ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
